// File: rtl/system_manager_cpu_mul_sequencer.sv
// Sequencer that drives the CPU 16x16 partial-product multiplier cell to build a
// 32x32 product, returning the low word (MUL) or the high word (MULX*) over valid/ready.
module system_manager_cpu_mul_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] E_src1,
  output logic [31:0] E_src2,
  output logic        M_en,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_CAP1  = 3'd2;
  localparam logic [2:0] ST_CAP2  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  logic [2:0]  state;
  logic [1:0]  op_p0;
  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic [31:0] ll_p1;
  logic [31:0] lh_p1;
  logic [31:0] hl_p1;
  logic [31:0] result;

  // Recombine unsigned partial products; signed high words are corrected by
  // subtracting the operand that the other operand's sign bit weighted by 2^32.
  function automatic logic [31:0] combine_word(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] ll,
    input logic [31:0] lh,
    input logic [31:0] hl,
    input logic [31:0] hh
  );
    logic [63:0] x;
    logic [63:0] p;
    logic [31:0] hi;
    x  = {32'd0, lh} + {32'd0, hl};
    p  = {32'd0, ll} + (x << 16) + ({32'd0, hh} << 32);
    hi = p[63:32];
    if (op == OP_MULXSU || op == OP_MULXSS)
      hi = hi - (a[31] ? b : 32'd0);
    if (op == OP_MULXSS)
      hi = hi - (b[31] ? a : 32'd0);
    return (op == OP_MUL) ? p[31:0] : hi;
  endfunction

  always_comb begin
    result = 32'd0;
    if (state == ST_CAP1)
      result = combine_word(op_p0, a_p0, b_p0, M_mul_cell_p1, M_mul_cell_p2,
                            M_mul_cell_p3, 32'd0);
    else if (state == ST_CAP2)
      result = combine_word(op_p0, a_p0, b_p0, ll_p1, lh_p1, hl_p1, M_mul_cell_p2);
  end

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_p0     <= 2'd0;
      a_p0      <= 32'd0;
      b_p0      <= 32'd0;
      ll_p1     <= 32'd0;
      lh_p1     <= 32'd0;
      hl_p1     <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      E_src1    <= 32'd0;
      E_src2    <= 32'd0;
      M_en      <= 1'b0;
    end else begin
      case (state)
        // Accept: operands go straight to the cell so pass 1 is sampled next edge
        ST_IDLE: begin
          if (req_valid) begin
            op_p0  <= req_op;
            a_p0   <= req_a;
            b_p0   <= req_b;
            E_src1 <= req_a;
            E_src2 <= req_b;
            M_en   <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        // Pass 1 sampled by the cell; high ops set up the half-swapped pass 2
        ST_ISSUE: begin
          if (op_p0 != OP_MUL) begin
            E_src1 <= {a_p0[15:0], a_p0[31:16]};
            M_en   <= 1'b1;
          end else begin
            M_en   <= 1'b0;
          end
          state <= ST_CAP1;
        end
        // Pass 1 products on the cell outputs
        ST_CAP1: begin
          ll_p1 <= M_mul_cell_p1;
          lh_p1 <= M_mul_cell_p2;
          hl_p1 <= M_mul_cell_p3;
          M_en  <= 1'b0;
          if (op_p0 == OP_MUL) begin
            rsp_data  <= result;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            state <= ST_CAP2;
          end
        end
        // Pass 2: only p2 (a_hi*b_hi) is meaningful
        ST_CAP2: begin
          rsp_data  <= result;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          M_en      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
